// File: rtl/div_pkg.sv
// Shared definitions for the radix-4 sequential divider.
//   DEF_DIV_WIDTH : default operand/result width
//   div_state_e   : controller state encoding
//   cnt_width()   : width of the iteration counter for a given iteration count
package div_pkg;

    localparam int DEF_DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ITER  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } div_state_e;

    function automatic int cnt_width(input int iters);
        return (iters > 1) ? $clog2(iters) : 1;
    endfunction

endpackage

// File: rtl/div_r4_step.sv
// One radix-4 restoring division step (purely combinational).
//   rem_in  : current partial remainder, always < D
//   pair_in : next two dividend bits, MSB first
//   d1/d2/d3: D, 2D, 3D at W+2 bits
//   rem_out : new partial remainder (< D)
//   digit   : quotient digit 0..3
module div_r4_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic [1:0]   pair_in,
    input  logic [W+1:0] d1,
    input  logic [W+1:0] d2,
    input  logic [W+1:0] d3,
    output logic [W-1:0] rem_out,
    output logic [1:0]   digit
);

    logic [W+1:0] cand;
    logic [W+1:0] kd;

    assign cand = {rem_in, pair_in};

    always_comb begin
        digit = 2'd0;
        kd    = '0;
        if (cand >= d3) begin
            digit = 2'd3;
            kd    = d3;
        end else if (cand >= d2) begin
            digit = 2'd2;
            kd    = d2;
        end else if (cand >= d1) begin
            digit = 2'd1;
            kd    = d1;
        end
    end

    // The difference is known to be < D < 2^W, so the low W bits carry it exactly.
    assign rem_out = cand[W-1:0] - kd[W-1:0];

endmodule

// File: rtl/div_radix4_seq.sv
// Sequential signed divider, radix-4 (2 quotient bits per clock).
//   clock, reset_n      : rising-edge clock, synchronous active-low reset
//   ctrl_div            : start pulse; operands sampled on the same edge (IDLE or DONE)
//   data_operandA/B     : signed dividend / divisor
//   data_quotient       : signed quotient, truncated toward zero
//   data_remainder      : signed remainder, sign of the dividend
//   data_exception      : divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY      : one-cycle result-valid pulse
//   busy                : high in SETUP, ITER and FIX
module div_radix4_seq
    import div_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH,
    parameter int DIV_ITERS = DIV_WIDTH / 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        ctrl_div,
    input  logic signed [DIV_WIDTH-1:0] data_operandA,
    input  logic signed [DIV_WIDTH-1:0] data_operandB,
    output logic signed [DIV_WIDTH-1:0] data_quotient,
    output logic signed [DIV_WIDTH-1:0] data_remainder,
    output logic                        data_exception,
    output logic                        data_resultRDY,
    output logic                        busy
);

    localparam int W  = DIV_WIDTH;
    localparam int CW = cnt_width(DIV_ITERS);
    localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

    function automatic logic [W-1:0] neg_if(input logic neg, input logic [W-1:0] v);
        return neg ? (~v + W'(1)) : v;
    endfunction

    div_state_e          state_q, state_d;
    logic signed [W-1:0] a_q, a_d, b_q, b_d;
    logic [W+1:0]        d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [W-1:0]        rem_q, rem_d;
    logic [W-1:0]        qsh_q, qsh_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic [W-1:0]        quo_q, quo_d, remo_q, remo_d;
    logic                exc_q, exc_d;

    logic [W-1:0]        a_abs, b_abs;
    logic [W-1:0]        step_rem;
    logic [1:0]          step_digit;

    // Most negative value maps to itself, which is the correct unsigned magnitude.
    assign a_abs = neg_if(a_q[W-1], a_q);
    assign b_abs = neg_if(b_q[W-1], b_q);

    div_r4_step #(.W(W)) u_step (
        .rem_in  (rem_q),
        .pair_in (qsh_q[W-1:W-2]),
        .d1      (d1_q),
        .d2      (d2_q),
        .d3      (d3_q),
        .rem_out (step_rem),
        .digit   (step_digit)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        rem_d   = rem_q;
        qsh_d   = qsh_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        exc_d   = exc_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (ctrl_div) begin
                    a_d     = data_operandA;
                    b_d     = data_operandB;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                q_neg_d = a_q[W-1] ^ b_q[W-1];
                r_neg_d = a_q[W-1];
                d1_d    = {2'b00, b_abs};
                d2_d    = {1'b0, b_abs, 1'b0};
                d3_d    = {2'b00, b_abs} + {1'b0, b_abs, 1'b0};
                rem_d   = '0;
                qsh_d   = a_abs;
                cnt_d   = '0;
                if (b_q == '0) begin
                    quo_d   = '0;
                    remo_d  = '0;
                    exc_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                // Dividend bits leave the top while quotient digits enter the bottom.
                rem_d = step_rem;
                qsh_d = {qsh_q[W-3:0], step_digit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = neg_if(q_neg_q, qsh_q);
                remo_d  = neg_if(r_neg_q, rem_q);
                exc_d   = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            exc_q   <= exc_d;
        end
    end

    always_ff @(posedge clock) begin
        a_q     <= a_d;
        b_q     <= b_d;
        d1_q    <= d1_d;
        d2_q    <= d2_d;
        d3_q    <= d3_d;
        rem_q   <= rem_d;
        qsh_q   <= qsh_d;
        q_neg_q <= q_neg_d;
        r_neg_q <= r_neg_d;
    end

    assign data_quotient  = quo_q;
    assign data_remainder = remo_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == SETUP) || (state_q == ITER) || (state_q == FIX);

endmodule
